// File: rtl/prbs_pkg.sv
// Shared types and per-polynomial constants for the PRBS generator/checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    PRBS7  = 2'd0,
    PRBS15 = 2'd1,
    PRBS23 = 2'd2,
    PRBS31 = 2'd3
  } prbs_mode_e;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // Widest polynomial degree; generator state and checker history use this width.
  localparam int STATE_W = 31;

  // Degree L (also the first tap t1) and second tap t2 per polynomial.
  localparam int PRBS7_L  = 7;
  localparam int PRBS7_T2 = 6;
  localparam int PRBS15_L  = 15;
  localparam int PRBS15_T2 = 14;
  localparam int PRBS23_L  = 23;
  localparam int PRBS23_T2 = 18;
  localparam int PRBS31_L  = 31;
  localparam int PRBS31_T2 = 28;

  // Mask covering the low L bits of a state for the given polynomial.
  function automatic logic [STATE_W-1:0] mode_mask(input prbs_mode_e m);
    case (m)
      PRBS7:   return STATE_W'((64'd1 << PRBS7_L) - 64'd1);
      PRBS15:  return STATE_W'((64'd1 << PRBS15_L) - 64'd1);
      PRBS23:  return STATE_W'((64'd1 << PRBS23_L) - 64'd1);
      default: return STATE_W'((64'd1 << PRBS31_L) - 64'd1);
    endcase
  endfunction

  // Feedback bit S[t1-1] ^ S[t2-1] for the given polynomial.
  function automatic logic tap_fb(input logic [STATE_W-1:0] s, input prbs_mode_e m);
    case (m)
      PRBS7:   return s[PRBS7_L-1]  ^ s[PRBS7_T2-1];
      PRBS15:  return s[PRBS15_L-1] ^ s[PRBS15_T2-1];
      PRBS23:  return s[PRBS23_L-1] ^ s[PRBS23_T2-1];
      default: return s[PRBS31_L-1] ^ s[PRBS31_T2-1];
    endcase
  endfunction

endpackage

// File: rtl/prbs_step.sv
// Combinational DATA_W-step Fibonacci LFSR advance; first bit in time lands in the word MSB.
module prbs_step
  import prbs_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [STATE_W-1:0] state_i,
  input  prbs_mode_e         mode_i,
  output logic [STATE_W-1:0] state_o,
  output logic [DATA_W-1:0]  word_o
);

  // Unrolled serial steps: each feedback bit is both the output bit and the shifted-in bit.
  always_comb begin
    state_o = state_i;
    word_o  = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      word_o[i] = tap_fb(state_o, mode_i);
      state_o   = {state_o[STATE_W-2:0], word_o[i]};
    end
  end

endmodule

// File: rtl/prbs_gen_chk.sv
// Parallel PRBS generator plus self-synchronising checker with lock FSM and BER counter.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ERR_CNT_W  = 16,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 gen_en,
  input  logic                 seed_load,
  input  logic [30:0]          seed,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic [DATA_W-1:0]    rx_data,
  input  logic                 rx_valid,
  input  logic                 chk_clr,
  output logic [1:0]           chk_state,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W  = 7;                    // popcount of up to 64 bits
  localparam int SUM_W  = ERR_CNT_W + CNT_W;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

  prbs_mode_e mode_e;
  assign mode_e = prbs_mode_e'(mode);

  // ---------------- generator ----------------
  logic [STATE_W-1:0] gen_state_q, gen_state_d, seed_fixed;
  logic [DATA_W-1:0]  tx_data_q, gen_word_d;
  logic               tx_valid_q;

  prbs_step #(.DATA_W(DATA_W)) u_step (
    .state_i (gen_state_q),
    .mode_i  (mode_e),
    .state_o (gen_state_d),
    .word_o  (gen_word_d)
  );

  // An all-zero seed would lock up the LFSR, so substitute all-ones.
  always_comb begin
    seed_fixed = seed & mode_mask(mode_e);
    if (seed_fixed == '0) seed_fixed = mode_mask(mode_e);
  end

  // Generator state and output word; seed load takes priority and emits no word.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_state_q <= '1;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
    end else if (seed_load) begin
      gen_state_q <= seed_fixed;
      tx_valid_q  <= 1'b0;
    end else if (gen_en) begin
      gen_state_q <= gen_state_d;
      tx_data_q   <= gen_word_d;
      tx_valid_q  <= 1'b1;
    end else begin
      tx_valid_q  <= 1'b0;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

  // ---------------- checker ----------------
  logic [STATE_W-1:0]   hist_q, hist_d;
  logic [CNT_W-1:0]     mm_cnt;
  logic                 word_err;
  logic [SUM_W-1:0]     err_sum;
  logic [ERR_CNT_W-1:0] err_q, err_sat;
  chk_state_e           state_q;
  logic                 locked_q;
  logic [GOOD_W-1:0]    good_q;
  logic [BAD_W-1:0]     bad_q;
  logic                 good_hit, bad_hit;

  // Predict each rx bit from the received history itself, count mismatches,
  // and flag a word whose resulting history is all zero (dead link).
  always_comb begin
    hist_d = hist_q;
    mm_cnt = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      mm_cnt = mm_cnt + CNT_W'(rx_data[i] ^ tap_fb(hist_d, mode_e));
      hist_d = {hist_d[STATE_W-2:0], rx_data[i]};
    end
    word_err = (mm_cnt != '0) || ((hist_d & mode_mask(mode_e)) == '0);
  end

  // Saturating accumulate of this word's mismatches.
  always_comb begin
    err_sum  = SUM_W'(err_q) + SUM_W'(mm_cnt);
    err_sat  = (|err_sum[SUM_W-1:ERR_CNT_W]) ? '1 : err_sum[ERR_CNT_W-1:0];
    good_hit = (good_q == GOOD_W'(LOCK_CNT - 1));
    bad_hit  = (bad_q == BAD_W'(UNLOCK_CNT - 1));
  end

  // Lock FSM, history and error counter; chk_clr overrides any rx word that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q   <= '1;
      state_q  <= HUNT;
      locked_q <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
      err_q    <= '0;
    end else if (chk_clr) begin
      state_q  <= HUNT;
      locked_q <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
      err_q    <= '0;
    end else if (rx_valid) begin
      hist_q <= hist_d;
      if (state_q == LOCKED) err_q <= err_sat;
      case (state_q)
        HUNT: begin
          if (!word_err) begin
            if (LOCK_CNT == 1) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              good_q   <= '0;
            end else begin
              state_q <= VERIFY;
              good_q  <= GOOD_W'(1);
            end
          end
        end
        VERIFY: begin
          if (word_err) begin
            state_q <= HUNT;
            good_q  <= '0;
          end else if (good_hit) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            good_q   <= '0;
          end else begin
            good_q <= good_q + GOOD_W'(1);
          end
        end
        LOCKED: begin
          if (word_err) begin
            if (bad_hit) begin
              state_q  <= HUNT;
              locked_q <= 1'b0;
              bad_q    <= '0;
            end else begin
              bad_q <= bad_q + BAD_W'(1);
            end
          end else begin
            bad_q <= '0;
          end
        end
        default: begin
          state_q  <= HUNT;
          locked_q <= 1'b0;
          good_q   <= '0;
          bad_q    <= '0;
        end
      endcase
    end
  end

  assign chk_state = state_q;
  assign locked    = locked_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Randomised bench for prbs_gen_chk against a bit-history recurrence model.
module tb_prbs_gen_chk;

  localparam int DW = 8;
  localparam int EW = 4;
  localparam int LC = 64;
  localparam int UC = 4;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, gen_en, seed_load, rx_valid, chk_clr;
  logic [1:0]    mode;
  logic [30:0]   seed;
  logic [DW-1:0] rx_data;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic [1:0]    chk_state;
  logic          locked;
  logic [EW-1:0] err_cnt;

  prbs_gen_chk #(
    .DATA_W(DW), .ERR_CNT_W(EW), .LOCK_CNT(LC), .UNLOCK_CNT(UC)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .gen_en(gen_en),
    .seed_load(seed_load), .seed(seed), .tx_data(tx_data), .tx_valid(tx_valid),
    .rx_data(rx_data), .rx_valid(rx_valid), .chk_clr(chk_clr),
    .chk_state(chk_state), .locked(locked), .err_cnt(err_cnt)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  string phase = "init";

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: the generator and receiver are kept as plain bit histories
  // (newest bit at the back); each new bit is the XOR of the bits t1 and t2 back.
  bit            gq[$];
  bit            rq[$];
  logic [DW-1:0] m_tx;
  bit            m_txv;
  int            m_state, m_good, m_bad, m_err;

  function automatic int plen(input int md);
    case (md)
      0: return 7;
      1: return 15;
      2: return 23;
      default: return 31;
    endcase
  endfunction

  function automatic int ptap2(input int md);
    case (md)
      0: return 6;
      1: return 14;
      2: return 18;
      default: return 28;
    endcase
  endfunction

  task automatic model_reset();
    gq.delete();
    rq.delete();
    for (int k = 0; k < 31; k++) begin
      gq.push_back(1'b1);
      rq.push_back(1'b1);
    end
    m_tx = '0; m_txv = 1'b0;
    m_state = 0; m_good = 0; m_bad = 0; m_err = 0;
  endtask

  task automatic model_clock();
    int L, t2, mm;
    bit b, p, zero, errd;
    logic [30:0] s;
    longint unsigned msk;
    if (reset) begin
      model_reset();
      return;
    end
    L   = plen(int'(mode));
    t2  = ptap2(int'(mode));
    msk = (64'd1 << L) - 64'd1;
    // generator
    if (seed_load) begin
      s = seed & 31'(msk);
      if (s == 31'd0) s = 31'(msk);
      gq.delete();
      for (int k = 30; k >= 0; k--) gq.push_back(s[k]);
      m_txv = 1'b0;
    end else if (gen_en) begin
      for (int i = DW - 1; i >= 0; i--) begin
        b = gq[31 - L] ^ gq[31 - t2];
        gq.push_back(b);
        void'(gq.pop_front());
        m_tx[i] = b;
      end
      m_txv = 1'b1;
    end else begin
      m_txv = 1'b0;
    end
    // checker
    if (chk_clr) begin
      m_err = 0; m_state = 0; m_good = 0; m_bad = 0;
    end else if (rx_valid) begin
      mm = 0;
      for (int i = DW - 1; i >= 0; i--) begin
        b = rx_data[i];
        p = rq[31 - L] ^ rq[31 - t2];
        mm += int'(b ^ p);
        rq.push_back(b);
        void'(rq.pop_front());
      end
      zero = 1'b1;
      for (int k = 0; k < L; k++) if (rq[30 - k]) zero = 1'b0;
      errd = (mm != 0) || zero;
      if (m_state == 2) m_err = (m_err + mm > ERR_MAX) ? ERR_MAX : m_err + mm;
      case (m_state)
        0: if (!errd) begin
             if (LC == 1) m_state = 2;
             else begin m_state = 1; m_good = 1; end
           end
        1: if (errd) begin
             m_state = 0; m_good = 0;
           end else begin
             m_good++;
             if (m_good >= LC) begin m_state = 2; m_good = 0; end
           end
        default: if (errd) begin
             m_bad++;
             if (m_bad >= UC) begin m_state = 0; m_bad = 0; end
           end else m_bad = 0;
      endcase
    end
  endtask

  // One clock: let the DUT sample, advance the model, compare every output.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_clock();
    check_val({phase, ":tx_data"},   64'(tx_data),   64'(m_tx));
    check_val({phase, ":tx_valid"},  64'(tx_valid),  64'(m_txv));
    check_val({phase, ":chk_state"}, 64'(chk_state), 64'(m_state));
    check_val({phase, ":locked"},    64'(locked),    64'(m_state == 2));
    check_val({phase, ":err_cnt"},   64'(err_cnt),   64'(m_err));
  endtask

  // Loopback: each cycle delivers the previous generated word (optionally inverted).
  task automatic loop_run(input int n, input bit inv);
    for (int k = 0; k < n; k++) begin
      gen_en   = 1'b1;
      rx_valid = m_txv;
      rx_data  = inv ? ~m_tx : m_tx;
      cycle();
    end
  endtask

  // Stop generating, deliver the last word, then clear the checker.
  task automatic drain_and_clear();
    gen_en = 1'b0; rx_valid = m_txv; rx_data = m_tx;
    cycle();
    rx_valid = 1'b0; chk_clr = 1'b1;
    cycle();
    chk_clr = 1'b0;
  endtask

  task automatic note(input string what);
    $display("phase %s: %s (%0d checks so far)", phase, what, chk_cnt);
  endtask

  initial begin
    reset = 1'b1; mode = 2'd0; gen_en = 1'b0; seed_load = 1'b0; seed = '0;
    rx_valid = 1'b0; rx_data = '0; chk_clr = 1'b0;
    model_reset();

    phase = "reset";
    cycle(); cycle();
    check_val("reset_err", 64'(err_cnt), 64'd0);
    note("reset values");
    reset = 1'b0;

    phase = "golden";
    gen_en = 1'b1;
    cycle();
    check_val("golden_w0", 64'(tx_data), 64'h02);
    cycle();
    check_val("golden_w1", 64'(tx_data), 64'h0C);
    check_val("golden_valid", 64'(tx_valid), 64'd1);
    gen_en = 1'b0;
    cycle();
    note("PRBS7 words 0x02, 0x0C");

    phase = "seed0";
    seed = 31'($urandom) & 31'h7fffff80;
    seed_load = 1'b1; gen_en = 1'b1;
    cycle();
    check_val("seed0_no_word", 64'(tx_valid), 64'd0);
    seed_load = 1'b0;
    cycle();
    check_val("seed0_restart", 64'(tx_data), 64'h02);
    gen_en = 1'b0;
    note("zero seed restarts sequence");

    phase = "rand_seed";
    for (int r = 0; r < 4; r++) begin
      mode = 2'($urandom_range(0, 3)); seed = 31'($urandom);
      seed_load = 1'b1; chk_clr = 1'b1;
      cycle();
      seed_load = 1'b0; chk_clr = 1'b0;
      for (int k = 0; k < 20; k++) begin
        gen_en = 1'($urandom_range(0, 1));
        cycle();
      end
    end
    gen_en = 1'b0;
    note("random seeds in all modes");

    phase = "zero_rx";
    reset = 1'b1; mode = 2'd0;
    cycle();
    reset = 1'b0; rx_valid = 1'b1; rx_data = '0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      check_val("zero_rx_hunt", 64'(chk_state), 64'd0);
    end
    rx_valid = 1'b0;
    note("all-zero stream stays in HUNT");

    phase = "lock31";
    mode = 2'd3; seed = 31'($urandom) | 31'd1;
    seed_load = 1'b1; chk_clr = 1'b1;
    cycle();
    seed_load = 1'b0; chk_clr = 1'b0;
    loop_run(10000, 1'b0);
    check_val("lock31_locked", 64'(locked), 64'd1);
    check_val("lock31_err", 64'(err_cnt), 64'd0);
    note("PRBS31 loopback locked over 10k words");

    phase = "single_err";
    gen_en = 1'b1; rx_valid = m_txv;
    rx_data = m_tx ^ (DW'(1) << $urandom_range(0, DW - 1));
    cycle();
    loop_run(10, 1'b0);
    check_val("single_err_cnt", 64'(err_cnt), 64'd3);
    check_val("single_err_locked", 64'(locked), 64'd1);
    note("one line error counts 3");

    phase = "unlock";
    drain_and_clear();
    check_val("clr_err", 64'(err_cnt), 64'd0);
    loop_run(80, 1'b0);
    check_val("relock", 64'(locked), 64'd1);
    loop_run(UC, 1'b1);
    check_val("unlock_hunt", 64'(chk_state), 64'd0);
    check_val("unlock_sat", 64'(err_cnt), 64'(ERR_MAX));
    loop_run(10, 1'b0);
    check_val("unlock_err_held", 64'(err_cnt), 64'(ERR_MAX));
    note("inverted words unlock, counter saturates");

    phase = "clear";
    drain_and_clear();
    check_val("clear_err", 64'(err_cnt), 64'd0);
    check_val("clear_hunt", 64'(chk_state), 64'd0);
    note("chk_clr");

    phase = "mid_reset";
    loop_run(80, 1'b0);
    gen_en = 1'b1; rx_valid = m_txv; rx_data = m_tx ^ DW'(1);
    cycle();
    loop_run(6, 1'b0);
    reset = 1'b1; gen_en = 1'b1; rx_valid = 1'b1; seed_load = 1'b1; rx_data = m_tx;
    cycle();
    check_val("mid_reset_tx", 64'(tx_data), 64'd0);
    check_val("mid_reset_valid", 64'(tx_valid), 64'd0);
    check_val("mid_reset_state", 64'(chk_state), 64'd0);
    check_val("mid_reset_locked", 64'(locked), 64'd0);
    check_val("mid_reset_err", 64'(err_cnt), 64'd0);
    reset = 1'b0; seed_load = 1'b0; gen_en = 1'b0; rx_valid = 1'b0;
    note("reset mid-stream");

    phase = "random";
    for (int k = 0; k < 400; k++) begin
      reset     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      seed      = 31'($urandom);
      seed_load = ($urandom_range(0, 9) == 0);
      gen_en    = ($urandom_range(0, 9) < 7);
      chk_clr   = ($urandom_range(0, 29) == 0);
      rx_valid  = ($urandom_range(0, 9) < 7);
      rx_data   = ($urandom_range(0, 3) == 0) ? DW'($urandom) : m_tx;
      cycle();
    end
    note("random traffic");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
